// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and write-back stage with a data-memory handshake,
// an ack timeout, and flush-based write-back suppression.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 4,
  parameter int RA_REG  = 15,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_sdata,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_isld,
  input  logic               in_isst,
  input  logic               in_iswb,
  input  logic               in_iscall,
  input  logic               flush,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err_timeout
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic wb_q, ld_wb, is_call, killed;
  logic accept, is_mem, last;
  assign in_ready = state == IDLE;
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_isld | in_isst;
  assign last     = cnt == CW'(TIMEOUT - 1);
  // A flush also kills a write-back that is already presented this cycle.
  assign wb_en    = wb_q & ~flush;
  always_comb
    state_nx = state == IDLE ? (accept && !flush && is_mem ? ACCESS : IDLE)
                             : (dmem_ack || last ? IDLE : ACCESS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wb_q        <= 1'b0;
      ld_wb       <= 1'b0;
      is_call     <= 1'b0;
      killed      <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wb_q        <= 1'b0;
      err_timeout <= 1'b0;
      if (accept && !flush) begin
        dmem_addr  <= in_alu[ADDR_W-1:0];
        dmem_wdata <= in_sdata;
        wb_addr    <= in_iscall ? RADDR_W'(RA_REG) : in_rd;
        wb_data    <= in_iscall ? in_pc + DATA_W'(4) : in_alu;
        is_call    <= in_iscall;
        ld_wb      <= in_isld & ~in_isst & (in_iswb | in_iscall);
        killed     <= 1'b0;
        cnt        <= '0;
        dmem_req   <= is_mem;
        dmem_we    <= in_isst;
        wb_q       <= ~is_mem & (in_iswb | in_iscall);
      end else if (state == ACCESS) begin
        killed <= killed | flush;
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          wb_q     <= ld_wb & ~killed & ~flush;
          if (!is_call) wb_data <= dmem_rdata;
        end else if (last) begin
          dmem_req    <= 1'b0;
          dmem_we     <= 1'b0;
          err_timeout <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and memory data width.
REQ-002 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-003 SHALL have parameter RADDR_W, default 4, register-file address width.
REQ-004 SHALL have parameter RA_REG, default 15, return-address register written by calls.
REQ-005 SHALL have parameter TIMEOUT, default 16, max cycles waiting for dmem_ack (>=2).
REQ-006 SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  upstream instruction valid.
REQ-010 in_ready  out  1  stage can accept this cycle.
REQ-011 in_pc  in  DATA_W  instruction PC.
REQ-012 in_alu  in  DATA_W  ALU result / effective address.
REQ-013 in_sdata  in  DATA_W  store data.
REQ-014 in_rd  in  RADDR_W  destination register.
REQ-015 in_isld, in_isst, in_iswb, in_iscall  in  1 each  decoded control flags.
REQ-016 flush  in  1  kill accepted/in-flight instruction writeback.
REQ-017 dmem_req, dmem_we  out  1 each  memory request, write-enable.
REQ-018 dmem_addr  out  ADDR_W  = in_alu[ADDR_W-1:0] captured at accept.
REQ-019 dmem_wdata  out  DATA_W  captured store data.
REQ-020 dmem_ack  in  1; dmem_rdata  in  DATA_W  memory completion and load data.
REQ-021 wb_en  out  1; wb_addr  out  RADDR_W; wb_data  out  DATA_W  register write port.
REQ-022 err_timeout  out  1  one-cycle pulse on memory timeout.

Function
REQ-023 SHALL implement states IDLE and ACCESS; in_ready = (state==IDLE).
REQ-024 Accept = in_valid && in_ready; accepted fields SHALL be captured at that edge.
REQ-025 Accepted non-memory op (isld=isst=0): state stays IDLE; next cycle wb_en=iswb|iscall for exactly one cycle; throughput one per cycle.
REQ-026 Write-back select: iscall -> wb_addr=RA_REG, wb_data=in_pc+4 modulo 2^DATA_W; else wb_addr=in_rd, wb_data=in_alu (non-load) or captured dmem_rdata (load).
REQ-027 Accepted memory op (isld|isst) SHALL go IDLE->ACCESS; dmem_req=1 from the following cycle, dmem_we=isst, addr/wdata stable until ack.
REQ-028 In ACCESS, dmem_ack=1 SHALL capture dmem_rdata, drop dmem_req next cycle, return to IDLE; load with iswb asserts wb_en the cycle after ack; store never asserts wb_en.
REQ-029 Wait counter SHALL clear on entering ACCESS, increment per ACCESS cycle without ack; reaching TIMEOUT-1 without ack SHALL return to IDLE, pulse err_timeout one cycle, suppress write-back.
REQ-030 Ack in the same cycle the counter reaches TIMEOUT-1 SHALL count as success (no error).
REQ-031 flush with accept in same cycle SHALL discard the instruction: no dmem_req, no wb_en, state IDLE.
REQ-032 flush in ACCESS SHALL NOT drop dmem_req (handshake completes) but SHALL suppress that instruction's wb_en.
REQ-033 flush in IDLE without accept SHALL suppress a wb_en due next cycle from the previous accept.
REQ-034 Both isld and isst set SHALL be treated as store.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, counter 0, dmem_req=0, dmem_we=0, wb_en=0, err_timeout=0, dmem_addr/dmem_wdata/wb_addr/wb_data=0; in_ready=1 after release.
REQ-036 Reset during ACCESS SHALL abandon the transaction; a late dmem_ack after release SHALL be ignored in IDLE.

Verification
REQ-037 ALU op in_alu=0x1234, in_rd=3, iswb=1 -> next cycle wb_en=1, wb_addr=3, wb_data=0x1234, one cycle only.
REQ-038 Load addr 0x40, ack after 3 cycles with rdata=0xDEADBEEF -> in_ready=0 throughout, wb_en=1, wb_data=0xDEADBEEF the cycle after ack.
REQ-039 Call in_pc=0xFFFFFFFC -> wb_addr=15, wb_data=0x00000000.
REQ-040 Store, no ack for TIMEOUT cycles -> err_timeout one-cycle pulse, no wb_en, in_ready=1 next cycle.
REQ-041 Load with flush mid-ACCESS, ack later -> dmem_req held until ack, wb_en stays 0.
REQ-042 rst_n low during ACCESS -> dmem_req=0 immediately; ack after release produces no wb_en.
